// File: rtl/fsm_symbol_gen_if.sv
// Symbol stream interface between the symbol sequencer and the y input of the FSM.
// master drives y/y_valid and samples y_ready; slave is the consuming FSM side.
interface fsm_symbol_gen_if;
  logic [1:0] y;
  logic       y_valid;
  logic       y_ready;

  modport master (output y, output y_valid, input y_ready);
  modport slave  (input y, input y_valid, output y_ready);
endinterface

// File: rtl/fsm_symbol_gen.sv
// Programmable 2-bit symbol sequencer.
// A short pattern of y-symbols is loaded while idle, then played out one symbol
// per accepted valid/ready transfer so the downstream FSM sees a repeatable stream.
// Optional feature macro: FSM_SYMBOL_GEN_LOOP_EN -- when defined, playback wraps to
// the first symbol after the last one and pulses done on every wrap instead of
// finishing; only stop or reset leaves playback.
module fsm_symbol_gen #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [1:0]          wr_data,
  input  logic                clr,
  input  logic                start,
  input  logic                stop,
  fsm_symbol_gen_if.master    sym,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic [AW:0]         count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state;
  state_t        state_next;
  logic [1:0]    pattern_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_next;
  logic          do_write;
  logic          play;
  logic          transfer;
  logic          last_symbol;
`ifdef FSM_SYMBOL_GEN_LOOP_EN
  logic          wrap;
  logic          wrap_q;
`endif

  // Outputs are decoded from the registered state and read pointer only, so
  // y_ready never reaches y_valid combinationally.
  assign play          = (state == PLAY);
  assign sym.y_valid   = play;
  assign sym.y         = play ? pattern_mem[rd_ptr] : 2'b00;
  assign busy          = play;
  assign full          = (count == CNT_MAX);
  assign transfer      = play && sym.y_ready;
  assign last_symbol   = ({1'b0, rd_ptr} == (count - CNT_ONE));

  // Next-state and pointer/count update decisions for all three states.
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    do_write    = 1'b0;
`ifdef FSM_SYMBOL_GEN_LOOP_EN
    wrap        = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // clr has priority over a same-cycle write; a write that fits is
        // counted before deciding whether start has anything to play.
        if (clr) begin
          wr_ptr_next = '0;
          count_next  = '0;
        end else if (wr_en && !full) begin
          do_write    = 1'b1;
          wr_ptr_next = wr_ptr + PTR_ONE;
          count_next  = count + CNT_ONE;
        end
        if (start && (count_next != '0)) begin
          state_next  = PLAY;
          rd_ptr_next = '0;
        end
      end
      PLAY: begin
        // stop aborts even when the current symbol is transferring.
        if (stop) begin
          state_next  = IDLE;
          rd_ptr_next = '0;
        end else if (transfer) begin
          if (last_symbol) begin
            rd_ptr_next = '0;
`ifdef FSM_SYMBOL_GEN_LOOP_EN
            wrap        = 1'b1;
`else
            state_next  = DONE;
`endif
          end else begin
            rd_ptr_next = rd_ptr + PTR_ONE;
          end
        end
      end
      DONE: begin
        state_next  = IDLE;
        rd_ptr_next = '0;
      end
      default: begin
        state_next  = IDLE;
        rd_ptr_next = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pointer and count registers; reset discards the stored pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Pattern storage; contents are don't-care after reset so it has no reset.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      pattern_mem[wr_ptr] <= wr_data;
    end
  end

`ifdef FSM_SYMBOL_GEN_LOOP_EN
  // Registered wrap pulse so done appears the cycle after the last symbol moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap;
    end
  end

  assign done = wrap_q;
`else
  assign done = (state == DONE);
`endif

endmodule

// File: tb/tb_fsm_symbol_gen.sv
// Self-checking bench for fsm_symbol_gen: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
// Honours FSM_SYMBOL_GEN_LOOP_EN in the model when the design is built with it.
module tb_fsm_symbol_gen;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_data;
  logic       clr;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;
  logic       full;
  logic [4:0] count;

  fsm_symbol_gen_if sym_if ();

  fsm_symbol_gen #(.DEPTH(16), .AW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr     (clr),
    .start   (start),
    .stop    (stop),
    .sym     (sym_if),
    .busy    (busy),
    .done    (done),
    .full    (full),
    .count   (count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the stored pattern as a queue, whether it is being played,
  // which element is on offer, and whether a done pulse is due this cycle.
  logic [1:0] pat_q[$];
  bit         playing  = 1'b0;
  bit         exp_done = 1'b0;
  int         pos      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("[TB] FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    if (reset) begin
      pat_q.delete();
      playing  = 1'b0;
      exp_done = 1'b0;
      pos      = 0;
    end else if (playing) begin
      exp_done = 1'b0;
      if (stop) begin
        playing = 1'b0;
        pos     = 0;
      end else if (sym_if.y_ready) begin
        if (pos == pat_q.size() - 1) begin
          pos      = 0;
          exp_done = 1'b1;
`ifndef FSM_SYMBOL_GEN_LOOP_EN
          playing  = 1'b0;
`endif
        end else begin
          pos++;
        end
      end
    end else if (exp_done) begin
      exp_done = 1'b0;
    end else begin
      if (clr) pat_q.delete();
      else if (wr_en && pat_q.size() < 16) pat_q.push_back(wr_data);
      if (start && pat_q.size() > 0) begin
        playing = 1'b1;
        pos     = 0;
      end
    end
  endtask

  task automatic checkAll();
    logic [1:0] exp_y;
    exp_y = playing ? pat_q[pos] : 2'b00;
    checkOutput("y_valid", 32'(sym_if.y_valid), 32'(playing));
    checkOutput("y",       32'(sym_if.y),       32'(exp_y));
    checkOutput("busy",    32'(busy),           32'(playing));
    checkOutput("done",    32'(done),           32'(exp_done));
    checkOutput("count",   32'(count),          32'(pat_q.size()));
    checkOutput("full",    32'(full),           32'(pat_q.size() == 16));
  endtask

  // Apply one cycle of inputs (called just after a negedge), clock it, then
  // compare on the following negedge.
  task automatic applyStimulus(input bit r, input bit w, input logic [1:0] d,
                               input bit c, input bit s, input bit p, input bit rdy);
    reset          = r;
    wr_en          = w;
    wr_data        = d;
    clr            = c;
    start          = s;
    stop           = p;
    sym_if.y_ready = rdy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 0, 0, 0, rdy);
  endtask

  task automatic loadPattern(input logic [1:0] syms[$]);
    foreach (syms[i]) applyStimulus(0, 1, syms[i], 0, 0, 0, 1);
  endtask

  initial begin
    logic [1:0] p1[$];
    logic [1:0] p2[$];
    logic [1:0] p3[$];
    p1 = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd3};
    p2 = '{2'd2, 2'd0, 2'd3};
    p3 = '{2'd1, 2'd2, 2'd3, 2'd0};

    reset = 1'b1; wr_en = 1'b0; wr_data = 2'd0; clr = 1'b0;
    start = 1'b0; stop = 1'b0; sym_if.y_ready = 1'b0;
    @(negedge clk);
    applyStimulus(1, 0, 2'd0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'd3, 0, 1, 0, 1);

    // Ten-symbol pattern played back-to-back.
    loadPattern(p1);
    applyStimulus(0, 0, 2'd0, 0, 1, 0, 1);
    idle(13, 1);

    // Three-symbol pattern with a consumer stall on the second symbol.
    applyStimulus(0, 0, 2'd0, 1, 0, 0, 1);
    loadPattern(p2);
    applyStimulus(0, 0, 2'd0, 0, 1, 0, 1);
    applyStimulus(0, 0, 2'd0, 0, 0, 0, 1);
    idle(3, 0);
    idle(4, 1);

    // Fill to capacity, overflow write, clear, start on empty.
    applyStimulus(0, 0, 2'd0, 1, 0, 0, 1);
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 2'(i), 0, 0, 0, 1);
    applyStimulus(0, 1, 2'd3, 1, 0, 0, 1);
    applyStimulus(0, 0, 2'd0, 0, 1, 0, 1);
    idle(2, 1);

    // Abort with stop while a transfer happens, then replay from the start.
    loadPattern(p3);
    applyStimulus(0, 0, 2'd0, 0, 1, 0, 1);
    idle(2, 1);
    applyStimulus(0, 0, 2'd0, 0, 0, 1, 1);
    idle(1, 1);
    applyStimulus(0, 0, 2'd0, 0, 1, 0, 1);
    idle(6, 1);

    // Reset while symbol index 2 is on offer.
    applyStimulus(0, 0, 2'd0, 0, 1, 0, 1);
    idle(2, 1);
    applyStimulus(1, 0, 2'd0, 0, 0, 0, 1);
    idle(2, 1);

    // Start in the same cycle as the first write.
    applyStimulus(0, 1, 2'd2, 0, 1, 0, 1);
    idle(3, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 45),
                    2'($urandom),
                    ($urandom_range(0, 99) < 4),
                    ($urandom_range(0, 99) < 12),
                    ($urandom_range(0, 99) < 4),
                    ($urandom_range(0, 99) < 70));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
